// File: rtl/handshake_conn_fi_if.sv
// handshake_if
// Purpose : one valid/ready handshake channel carrying a DATA_W-bit beat.
//           A beat transfers on a rising clock edge where valid and ready
//           are both high. While valid is high and the beat has not
//           transferred, the sender keeps data stable.
// Signals : valid  sender -> receiver, beat present
//           data   sender -> receiver, beat payload
//           ready  receiver -> sender, receiver accepts this cycle
// Modports: sender   drives valid/data, samples ready
//           receiver samples valid/data, drives ready
`timescale 1ns/1ps

interface handshake_if #(
  parameter int DATA_W = 8
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport sender (
    output valid,
    output data,
    input  ready
  );

  modport receiver (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/handshake_conn_fi.sv
// handshake_conn_fi
// Purpose : round-robin fan-in. NUM_CHANNEL valid/ready input channels are
//           merged onto one output channel through a single registered
//           output stage. o_sel records the source channel of the held
//           beat so reply logic can route responses back through a fan-out.
// Params  : NUM_CHANNEL  number of input channels (must be >= 2)
//           DATA_W       beat width; must match the DATA_W of the
//                        connected handshake_if instances
//           SEL_W        channel index width, derived from NUM_CHANNEL
// Ports   : i_clk        rising-edge clock
//           i_rst_n      asynchronous active-low reset
//           rx_if[]      input channels (receiver side of each handshake)
//           tx_if        merged output channel (sender side)
//           o_sel        source channel of the beat on tx_if, valid only
//                        while tx_if.valid is high
`timescale 1ns/1ps

module handshake_conn_fi #(
  parameter  int NUM_CHANNEL = 2,
  parameter  int DATA_W      = 8,
  localparam int SEL_W       = $clog2(NUM_CHANNEL)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  handshake_if.receiver     rx_if [NUM_CHANNEL],
  handshake_if.sender       tx_if,
  output logic [SEL_W-1:0]  o_sel
);

  // A single channel has nothing to arbitrate and would also collapse the
  // index width to zero, so refuse to elaborate.
  if (NUM_CHANNEL < 2) begin : g_bad_num_channel
    $error("handshake_conn_fi: NUM_CHANNEL must be at least 2");
  end

  logic [NUM_CHANNEL-1:0] req;
  logic [DATA_W-1:0]      rx_data [NUM_CHANNEL];

  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       ptr;

  logic [SEL_W-1:0]       grant;
  logic                   any_req;
  logic                   load;

  // Flatten the interface array into plain vectors so arbitration can use
  // a computed index; interface array elements only take constant indices.
  // Ready is forced low during reset because the empty output stage would
  // otherwise look ready to load.
  for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_rx
    assign req[i]         = rx_if[i].valid;
    assign rx_data[i]     = rx_if[i].data;
    assign rx_if[i].ready = i_rst_n && load && any_req && (grant == SEL_W'(i));
  end

  assign any_req = |req;

  // The output register can take a new beat when it is empty or when the
  // beat it holds leaves on this same edge, which keeps full throughput.
  assign load = !out_valid || tx_if.ready;

  // Round-robin search: walk the channels starting at ptr and wrapping at
  // NUM_CHANNEL, taking the first requester. The wrap is done by
  // subtraction rather than bit truncation so non-power-of-two channel
  // counts never produce an out-of-range index.
  always_comb begin
    logic             found;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    grant = ptr;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_CHANNEL)) begin
        sum = sum - (SEL_W+1)'(NUM_CHANNEL);
      end
      idx = sum[SEL_W-1:0];
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Output stage and priority pointer. On a load, either capture the
  // granted beat and move priority just past the winner, or go empty when
  // nobody is requesting (data, o_sel and ptr keep their values). Without
  // a load the held beat is stalled and everything stays put.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      o_sel     <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= rx_data[grant];
        o_sel     <= grant;
        ptr       <= (grant == SEL_W'(NUM_CHANNEL-1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign tx_if.valid = out_valid;
  assign tx_if.data  = out_data;

endmodule

// File: tb/tb_handshake_conn_fi.sv
// tb_handshake_conn_fi
// Purpose : self-checking bench for handshake_conn_fi with five channels.
//           A transaction-level reference (held beat plus preferred
//           channel, grant chosen as the first requester at or after the
//           preferred channel) predicts ready and output values every
//           cycle. Directed steps cover reset, single channel, rotation,
//           backpressure and draining; a random phase adds a sequence-
//           number scoreboard and a wait-count bound per channel.
`timescale 1ns/1ps

module tb_handshake_conn_fi;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  handshake_if #(.DATA_W(DW)) rx_if [N] ();
  handshake_if #(.DATA_W(DW)) tx_if ();

  logic [N-1:0]  in_valid;
  logic [DW-1:0] in_data [N];
  logic [N-1:0]  dut_ready;
  logic          out_ready;
  logic [SW-1:0] dut_sel;

  for (genvar g = 0; g < N; g++) begin : g_drive
    assign rx_if[g].valid = in_valid[g];
    assign rx_if[g].data  = in_data[g];
    assign dut_ready[g]   = rx_if[g].ready;
  end

  assign tx_if.ready = out_ready;

  handshake_conn_fi #(
    .NUM_CHANNEL (N),
    .DATA_W      (DW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rx_if   (rx_if),
    .tx_if   (tx_if),
    .o_sel   (dut_sel)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_pref;

  // random-phase bookkeeping
  bit            sb_on;
  int            send_cnt [N];
  int            recv_cnt [N];
  int            wait_cnt [N];
  logic [N-1:0]  last_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickChannel(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_pref + k) % N]) return (m_pref + k) % N;
    end
    return -1;
  endfunction

  // Called on a falling edge with in_data already set. Applies valids and
  // tx ready, checks the cycle against the model, then advances one clock
  // and returns on the next falling edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy);
    int           g;
    int           ch;
    bit           will_load;
    logic [N-1:0] exp_ready;
    in_valid  = v;
    out_ready = rdy;
    #1;
    will_load = !m_valid || rdy;
    g         = pickChannel(v);
    exp_ready = '0;
    if (will_load && g >= 0) exp_ready[g] = 1'b1;
    checkOutput("rx_ready", dut_ready, exp_ready);
    checkOutput("tx_valid", tx_if.valid, m_valid);
    if (m_valid) begin
      checkOutput("tx_data", tx_if.data, m_data);
      checkOutput("o_sel", dut_sel, m_src);
    end
    last_ready = dut_ready;
    if (sb_on && tx_if.valid && rdy) begin
      ch = int'(tx_if.data[7:5]);
      if (ch < N) begin
        checkOutput("sb_sel", dut_sel, ch);
        checkOutput("sb_seq", tx_if.data[4:0], recv_cnt[ch] % 32);
        recv_cnt[ch]++;
      end else begin
        checkOutput("sb_chan_range", ch, N - 1);
      end
    end
    if (sb_on && (|dut_ready)) begin
      for (int c = 0; c < N; c++) begin
        if (dut_ready[c]) begin
          checkOutput("fair_wait_ok", wait_cnt[c] <= N - 1, 1);
          wait_cnt[c] = 0;
        end else if (v[c]) begin
          wait_cnt[c]++;
        end
      end
    end
    @(posedge clk);
    if (will_load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g];
        m_src   = g;
        m_pref  = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Called on a falling edge: asserts reset asynchronously between edges,
  // checks outputs respond immediately, releases on the next falling edge.
  task automatic resetDut();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_valid", tx_if.valid, 0);
    checkOutput("rst_tx_data", tx_if.data, 0);
    checkOutput("rst_o_sel", dut_sel, 0);
    checkOutput("rst_rx_ready", dut_ready, 0);
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_pref  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] nv;
    bit           rdy;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    sb_on     = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_src     = 0;
    m_pref    = 0;
    for (int c = 0; c < N; c++) in_data[c] = DW'(8'h10 + c);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset while a beat is held
    applyStimulus('1, 1'b0);
    applyStimulus('1, 1'b0);
    checkOutput("pre_rst_valid", tx_if.valid, 1);
    resetDut();
    applyStimulus('1, 1'b1);
    checkOutput("first_grant", last_ready, 5'b00001);

    // single requester on channel 2
    resetDut();
    in_data[2] = 8'hA5;
    applyStimulus(5'b00100, 1'b1);
    checkOutput("single_ready", last_ready, 5'b00100);
    checkOutput("single_valid", tx_if.valid, 1);
    checkOutput("single_data", tx_if.data, 8'hA5);
    checkOutput("single_sel", dut_sel, 2);
    applyStimulus('1, 1'b1);
    checkOutput("single_next_grant", last_ready, 5'b01000);
    in_data[2] = 8'h12;

    // rotation with every channel requesting
    resetDut();
    for (int k = 0; k < 2 * N; k++) begin
      applyStimulus('1, 1'b1);
      checkOutput("rr_grant", last_ready, 1 << (k % N));
      checkOutput("rr_valid", tx_if.valid, 1);
      checkOutput("rr_sel", dut_sel, k % N);
    end

    // backpressure with channels 0 and 1 requesting
    resetDut();
    applyStimulus(5'b00011, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(5'b00011, 1'b0);
      checkOutput("bp_ready", last_ready, 0);
      checkOutput("bp_data", tx_if.data, 8'h10);
      checkOutput("bp_sel", dut_sel, 0);
    end
    applyStimulus(5'b00011, 1'b1);
    checkOutput("bp_release_grant", last_ready, 5'b00010);
    checkOutput("bp_release_valid", tx_if.valid, 1);
    checkOutput("bp_release_data", tx_if.data, 8'h11);
    checkOutput("bp_release_sel", dut_sel, 1);

    // single beat drains to empty
    resetDut();
    applyStimulus(5'b00010, 1'b1);
    checkOutput("drain_valid_hi", tx_if.valid, 1);
    checkOutput("drain_sel", dut_sel, 1);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("drain_valid_lo", tx_if.valid, 0);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("drain_stays_lo", tx_if.valid, 0);

    // random traffic with scoreboard
    in_valid = '0;
    resetDut();
    for (int c = 0; c < N; c++) begin
      send_cnt[c] = 0;
      recv_cnt[c] = 0;
      wait_cnt[c] = 0;
    end
    sb_on      = 1'b1;
    last_ready = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (in_valid[c] && last_ready[c]) send_cnt[c]++;
        if (in_valid[c] && !last_ready[c]) nv[c] = 1'b1;
        else                               nv[c] = 1'($urandom_range(0, 1));
        in_data[c] = {3'(c), 5'(send_cnt[c])};
      end
      rdy = ($urandom_range(0, 9) < 7);
      applyStimulus(nv, rdy);
    end
    for (int c = 0; c < N; c++) begin
      if (in_valid[c] && last_ready[c]) send_cnt[c]++;
    end
    repeat (3) applyStimulus('0, 1'b1);
    for (int c = 0; c < N; c++) begin
      checkOutput("sb_count", recv_cnt[c], send_cnt[c]);
    end
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
